freq_word_ctrl: RTL and testbench
=================================

Name: freq_word_ctrl

Overview:
- Generates the DDS frequency control word (phase-accumulator step) from six active-low push-buttons.
- Fully synchronous successor to the asynchronous button-edge step generator; sits between the board buttons and the phase accumulator.
- Adds parametrised width, step sizes and limits; per-button synchronisation and debounce; deterministic priority; true saturating arithmetic; status flags.
- Optional auto-repeat while a button is held.

Parameters:
- W, 32, control-word width.
- STEP_INIT, 171798691, reset value of step (2 MHz).
- STEP_MIN, 858993, lower saturation limit.
- STEP_MAX, 171798691, upper saturation limit.
- DELTA_COARSE, 858993, coarse increment.
- DELTA_MID, 85899, medium increment.
- DELTA_FINE, 85, fine increment.
- DEBOUNCE_CYCLES, 500000, consecutive stable samples needed to change debounced state.
- REPEAT_DELAY, 25000000, hold cycles before the first auto-repeat (AUTO_REPEAT_EN only).
- REPEAT_PERIOD, 5000000, cycles between auto-repeats (AUTO_REPEAT_EN only).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- btn_n  in  6  active-low buttons, asynchronous to clk:
  - [0] coarse add, [1] coarse sub
  - [2] mid add, [3] mid sub
  - [4] fine add, [5] fine sub
- step  out  W  frequency control word, registered.
- step_update  out  1  one-cycle pulse when step changes value.
- at_max  out  1  high when step == STEP_MAX.
- at_min  out  1  high when step == STEP_MIN.

Behaviour:
- Reset: one clock; synchronous, active-high. Reset values:
  - step = STEP_INIT, step_update = 0.
  - at_max/at_min recomputed from STEP_INIT.
  - All synchronisers cleared to released (1).
  - Debounce counters = 0, debounced states = released, repeat timers = 0.
- Synchronisation: each btn_n bit passes through a 2-flop synchroniser; the inverted output is the raw press.
- Debounce (per button, independent):
  - Counter increments while raw press differs from the debounced state; it clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced state flips and the counter clears.
  - Pulses shorter than DEBOUNCE_CYCLES cycles have no effect.
- Event: a one-cycle pulse on the released->pressed transition of the debounced state.
- Arbitration: if several events fire in the same cycle, only the lowest-index one is applied; the others are discarded, not queued.
- Arithmetic: computed in W+1 bits, applied on the clock after the event cycle (1-cycle latency).
  - add: step <= (step + delta > STEP_MAX) ? STEP_MAX : step + delta.
  - sub: step <= (step < STEP_MIN + delta) ? STEP_MIN : step - delta.
  - No wrap-around in either direction.
- step_update: asserts in the same cycle step takes its new value, and only if that value differs from the old one. A press while already saturated produces no pulse.
- Flags: at_max/at_min are registered and updated together with step.
- Total press latency: 2 sync cycles + DEBOUNCE_CYCLES + 1 cycle from btn_n falling to step changing.
- Release generates no event.
- Reset mid-press: all state returns to released. A button still held after reset deasserts is re-debounced and produces one new event.
- Parameter legality (simulation assertion): STEP_MIN <= STEP_INIT <= STEP_MAX < 2^W.

Optional Feature:
- Macro: FREQ_WORD_CTRL_AUTO_REPEAT_EN.
- Defined:
  - Each button has a repeat timer, started at its press event.
  - After REPEAT_DELAY cycles of continuous debounced press, a repeat event fires, then one every REPEAT_PERIOD cycles until debounced release.
  - Repeat events go through the same arbitration and saturation as press events.
  - The timer clears on release or reset.
- Undefined: exactly one event per debounced press. Timers and repeat parameters are unused, with no logic generated.

Test Plan:
Bench params: DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4.
1. Reset for 2 cycles -> step=171798691, at_max=1, at_min=0, step_update=0. Hold btn_n[0] low 20 cycles -> step unchanged, no step_update pulse.
2. btn_n[1] low 20 cycles, then high -> exactly one step_update; step=170939698 on cycle 2+4+1 after the falling edge; at_max=0.
3. btn_n[3] low for 3 cycles (glitch) -> step unchanged. Then preload to 859043 via a fine-sub sequence and press btn_n[5] -> step=858993, at_min=1; a further press -> no change, no pulse.
4. Step=100000000, btn_n[0] and btn_n[1] fall in the same cycle -> step=100858993, single step_update.
5. Reset asserted while btn_n[4] is held low -> step=STEP_INIT after reset; 4+2 cycles after reset release, one fine-add event -> step saturates or changes as per limits.
6. With macro defined, step=100000000, hold btn_n[4] for 30 cycles after debounce:
   - Events fire at press, +8, +12, +16, +20, +24, +28.
   - Final step = 100000000 + 7*85 = 100000595.
   - With macro undefined, the same stimulus -> 100000085.

Source files
------------

// File: rtl/freq_word_ctrl.sv
// DDS frequency control word from six active-low buttons: sync, debounce, priority, saturating step.
// Optional auto-repeat while held: define FREQ_WORD_CTRL_AUTO_REPEAT_EN.
module freq_word_ctrl #(
    parameter int              W               = 32,
    parameter longint unsigned STEP_INIT       = 171798691,
    parameter longint unsigned STEP_MIN        = 858993,
    parameter longint unsigned STEP_MAX        = 171798691,
    parameter longint unsigned DELTA_COARSE    = 858993,
    parameter longint unsigned DELTA_MID       = 85899,
    parameter longint unsigned DELTA_FINE      = 85,
    parameter int              DEBOUNCE_CYCLES = 500000,
    parameter int              REPEAT_DELAY    = 25000000,
    parameter int              REPEAT_PERIOD   = 5000000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [5:0]   btn_n,
    output logic [W-1:0] step,
    output logic         step_update,
    output logic         at_max,
    output logic         at_min
);
    localparam int NB = 6;
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [W:0] P_INIT = (W+1)'(STEP_INIT);
    localparam logic [W:0] P_MIN  = (W+1)'(STEP_MIN);
    localparam logic [W:0] P_MAX  = (W+1)'(STEP_MAX);
    localparam logic [W:0] P_DC   = (W+1)'(DELTA_COARSE);
    localparam logic [W:0] P_DM   = (W+1)'(DELTA_MID);
    localparam logic [W:0] P_DF   = (W+1)'(DELTA_FINE);

    logic [NB-1:0] r_sync1, r_sync2, r_deb, r_evt;
    logic [CW-1:0] r_cnt [NB];
    logic [W-1:0]  r_step;
    logic          r_update, r_at_max, r_at_min;

    logic [NB-1:0] w_raw, w_deb_next, w_press, w_evt_next;
    logic [CW-1:0] w_cnt_next [NB];

    assign w_raw = ~r_sync2;

    // Counter only runs while raw and debounced disagree; any agreement restarts it.
    always_comb begin
        w_deb_next = r_deb;
        w_press    = '0;
        for (int i = 0; i < NB; i++) begin
            w_cnt_next[i] = '0;
            if (w_raw[i] != r_deb[i]) begin
                if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    w_deb_next[i] = ~r_deb[i];
                    w_press[i]    = ~r_deb[i];
                end else begin
                    w_cnt_next[i] = r_cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef FREQ_WORD_CTRL_AUTO_REPEAT_EN
    localparam int RW = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;

    logic [RW-1:0] r_tmr [NB];
    logic [RW-1:0] w_tmr_next [NB];
    logic [NB-1:0] w_rep;

    // After a repeat the timer reloads so the next one lands REPEAT_PERIOD cycles later.
    always_comb begin
        for (int i = 0; i < NB; i++) begin
            w_rep[i]      = r_deb[i] && (r_tmr[i] == RW'(REPEAT_DELAY - 1));
            w_tmr_next[i] = '0;
            if (!w_press[i] && r_deb[i]) begin
                w_tmr_next[i] = w_rep[i] ? RW'(REPEAT_DELAY - REPEAT_PERIOD) : r_tmr[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmr <= '{default: '0};
        end else begin
            r_tmr <= w_tmr_next;
        end
    end

    assign w_evt_next = w_press | w_rep;
`else
    assign w_evt_next = w_press;
`endif

    logic         w_sel_vld;
    logic [2:0]   w_sel_idx;
    logic [W:0]   w_delta, w_ext, w_sum;
    logic [W-1:0] w_next;

    // Lowest index wins; simultaneous losers are dropped.
    always_comb begin
        w_sel_vld = 1'b0;
        w_sel_idx = '0;
        for (int i = NB - 1; i >= 0; i--) begin
            if (r_evt[i]) begin
                w_sel_vld = 1'b1;
                w_sel_idx = 3'(i);
            end
        end
    end

    always_comb begin
        case (w_sel_idx[2:1])
            2'd0:    w_delta = P_DC;
            2'd1:    w_delta = P_DM;
            default: w_delta = P_DF;
        endcase
        w_ext  = {1'b0, r_step};
        w_sum  = w_ext + w_delta;
        w_next = r_step;
        if (w_sel_vld) begin
            if (!w_sel_idx[0]) begin
                w_next = (w_sum > P_MAX) ? P_MAX[W-1:0] : w_sum[W-1:0];
            end else begin
                w_next = (w_ext < P_MIN + w_delta) ? P_MIN[W-1:0] : r_step - w_delta[W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1  <= '1;
            r_sync2  <= '1;
            r_deb    <= '0;
            r_evt    <= '0;
            r_cnt    <= '{default: '0};
            r_step   <= P_INIT[W-1:0];
            r_update <= 1'b0;
            r_at_max <= (P_INIT == P_MAX);
            r_at_min <= (P_INIT == P_MIN);
        end else begin
            r_sync1  <= btn_n;
            r_sync2  <= r_sync1;
            r_deb    <= w_deb_next;
            r_evt    <= w_evt_next;
            r_cnt    <= w_cnt_next;
            r_step   <= w_next;
            r_update <= (w_next != r_step);
            r_at_max <= ({1'b0, w_next} == P_MAX);
            r_at_min <= ({1'b0, w_next} == P_MIN);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            assert ((STEP_MIN <= STEP_INIT) && (STEP_INIT <= STEP_MAX) &&
                    ((W >= 64) || (STEP_MAX < (64'd1 << W))) &&
                    (DEBOUNCE_CYCLES >= 1) && (REPEAT_PERIOD >= 1) &&
                    (REPEAT_DELAY >= REPEAT_PERIOD));
        end
    end

    assign step        = r_step;
    assign step_update = r_update;
    assign at_max      = r_at_max;
    assign at_min      = r_at_min;
endmodule

// File: tb/tb_freq_word_ctrl.sv
// Directed bench for freq_word_ctrl with short debounce/repeat timing.
module tb_freq_word_ctrl;
    localparam int W = 32;
    localparam longint unsigned P_INIT = 171798691;
    localparam longint unsigned P_MIN  = 858993;
    localparam longint unsigned P_MAX  = 171798691;

    logic         clk = 1'b0;
    logic         reset;
    logic [5:0]   btn_n;
    logic [W-1:0] step;
    logic         step_update;
    logic         at_max;
    logic         at_min;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pulse  = 0;
    longint unsigned m_step;
    logic [W-1:0] exp_q[$];

    freq_word_ctrl #(
        .W(W), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(4)
    ) dut (
        .clk(clk), .reset(reset), .btn_n(btn_n), .step(step),
        .step_update(step_update), .at_max(at_max), .at_min(at_min)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard: every step_update must match the next queued expected word.
    always @(negedge clk) begin
        if (step_update) begin
            n_pulse++;
            check_eq("pulse_expected", longint'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check_eq("step_on_update", step, exp_q.pop_front());
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply(input int idx);
        longint unsigned d, nx;
        d = (idx < 2) ? 858993 : (idx < 4) ? 85899 : 85;
        if (idx % 2 == 0) nx = (m_step + d > P_MAX) ? P_MAX : m_step + d;
        else              nx = (m_step < P_MIN + d) ? P_MIN : m_step - d;
        if (nx != m_step) exp_q.push_back(W'(nx));
        m_step = nx;
    endtask

    task automatic press(input int idx);
        apply(idx);
        btn_n[idx] = 1'b0;
        wait_cyc(6);
        btn_n[idx] = 1'b1;
        wait_cyc(8);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n_ev;
        reset = 1'b1;
        btn_n = '1;
        m_step = P_INIT;
        wait_cyc(2);
        check_eq("rst_step", step, 171798691);
        check_eq("rst_at_max", at_max, 1);
        check_eq("rst_at_min", at_min, 0);
        check_eq("rst_update", step_update, 0);
        reset = 1'b0;

        // 1: coarse add while saturated at max
        base = n_pulse;
        apply(0);
        btn_n[0] = 1'b0;
        wait_cyc(20);
        btn_n[0] = 1'b1;
        wait_cyc(10);
        check_eq("max_hold_step", step, 171798691);
        check_eq("max_hold_pulses", n_pulse - base, 0);

        // 2: coarse sub latency, 20-cycle hold
`ifdef FREQ_WORD_CTRL_AUTO_REPEAT_EN
        n_ev = 5;
`else
        n_ev = 1;
`endif
        base = n_pulse;
        for (int k = 0; k < n_ev; k++) apply(1);
        btn_n[1] = 1'b0;
        wait_cyc(6);
        check_eq("lat_before", step, 171798691);
        wait_cyc(1);
        check_eq("lat_after", step, 170939698);
        check_eq("lat_update", step_update, 1);
        check_eq("lat_at_max", at_max, 0);
        wait_cyc(13);
        btn_n[1] = 1'b1;
        wait_cyc(10);
        check_eq("sub_pulses", n_pulse - base, n_ev);

        // 3: glitch rejection, then walk down to the lower limit
        base = n_pulse;
        btn_n[3] = 1'b0;
        wait_cyc(3);
        btn_n[3] = 1'b1;
        wait_cyc(10);
        check_eq("glitch_step", step, m_step);
        check_eq("glitch_pulses", n_pulse - base, 0);
        for (int k = 0; k < 199 - n_ev; k++) press(1);
        check_eq("near_min", step, 859084);
        press(5);
        check_eq("fine_sub", step, 858999);
        press(5);
        check_eq("sat_min_step", step, 858993);
        check_eq("sat_min_flag", at_min, 1);
        base = n_pulse;
        press(5);
        check_eq("min_hold_step", step, 858993);
        check_eq("min_hold_pulses", n_pulse - base, 0);
        check_eq("min_hold_flag", at_min, 1);

        // 4: climb, then simultaneous coarse add + sub -> add wins
        for (int k = 0; k < 10; k++) press(0);
        check_eq("climb", step, 9448923);
        base = n_pulse;
        apply(0);
        btn_n[1:0] = 2'b00;
        wait_cyc(6);
        btn_n[1:0] = 2'b11;
        wait_cyc(8);
        check_eq("prio_step", step, 10307916);
        check_eq("prio_pulses", n_pulse - base, 1);
        press(2);
        check_eq("mid_add", step, 10393815);

        // 6: fine add held long
`ifdef FREQ_WORD_CTRL_AUTO_REPEAT_EN
        n_ev = 7;
`else
        n_ev = 1;
`endif
        base = n_pulse;
        for (int k = 0; k < n_ev; k++) apply(4);
        btn_n[4] = 1'b0;
        wait_cyc(31);
        btn_n[4] = 1'b1;
        wait_cyc(12);
`ifdef FREQ_WORD_CTRL_AUTO_REPEAT_EN
        check_eq("hold_step", step, 10394410);
`else
        check_eq("hold_step", step, 10393900);
`endif
        check_eq("hold_pulses", n_pulse - base, n_ev);

        // 5: reset while fine sub is held
        apply(5);
        btn_n[5] = 1'b0;
        wait_cyc(10);
        reset = 1'b1;
        wait_cyc(2);
        check_eq("mid_rst_step", step, 171798691);
        check_eq("mid_rst_at_max", at_max, 1);
        check_eq("mid_rst_at_min", at_min, 0);
        check_eq("mid_rst_update", step_update, 0);
        check_eq("mid_rst_q", exp_q.size(), 0);
        m_step = P_INIT;
        reset = 1'b0;
        base = n_pulse;
        apply(5);
        wait_cyc(6);
        check_eq("rearm_before", step, 171798691);
        wait_cyc(1);
        check_eq("rearm_after", step, 171798606);
        check_eq("rearm_update", step_update, 1);
        btn_n[5] = 1'b1;
        wait_cyc(10);
        check_eq("rearm_pulses", n_pulse - base, 1);
        check_eq("rearm_at_max", at_max, 0);

        check_eq("q_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
